// File: rtl/playback_controller_pkg.sv
// Shared constants for the playback controller: key codes, FSM encoding, divisor defaults.
package playback_controller_pkg;

    // ASCII command codes carried on key_code
    localparam logic [7:0] KEY_PLAY    = 8'h45; // 'E'
    localparam logic [7:0] KEY_PAUSE   = 8'h44; // 'D'
    localparam logic [7:0] KEY_FORWARD = 8'h46; // 'F'
    localparam logic [7:0] KEY_BACK    = 8'h42; // 'B'
    localparam logic [7:0] KEY_RESTART = 8'h52; // 'R'

    // Sample-tick divisor defaults, in inclk cycles
    localparam int unsigned DIV_W           = 16;
    localparam int unsigned DIV_DEFAULT     = 2272; // 50 MHz / 22 kHz
    localparam int unsigned DIV_STEP_DEFAULT = 16;
    localparam int unsigned DIV_MIN_DEFAULT = 256;
    localparam int unsigned DIV_MAX_DEFAULT = 8192;

    typedef enum logic [1:0] {
        StPaused   = 2'd0,
        StIssue    = 2'd1,
        StWaitDone = 2'd2
    } state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divisor with saturating speed control and the free-running audio tick counter.
module sample_tick_gen
    import playback_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV_DEFAULT = DIV_DEFAULT,
    parameter int unsigned DIV_STEP        = DIV_STEP_DEFAULT,
    parameter int unsigned DIV_MIN         = DIV_MIN_DEFAULT,
    parameter int unsigned DIV_MAX         = DIV_MAX_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             speed_up_i,
    input  logic             speed_down_i,
    input  logic             speed_reset_i,
    output logic [DIV_W-1:0] clk_div_o,
    output logic             audio_clk_o
);

    localparam logic [DIV_W-1:0] Step    = DIV_W'(DIV_STEP);
    localparam logic [DIV_W-1:0] MinDiv  = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] MaxDiv  = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0] DefDiv  = DIV_W'(CLK_DIV_DEFAULT);
    localparam int unsigned      DecFloor = DIV_MIN + DIV_STEP;

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next divisor: reset wins, opposing strobes cancel, both directions saturate
    always_comb begin
        div_d = div_q;
        if (speed_reset_i) begin
            div_d = DefDiv;
        end else if (speed_up_i && !speed_down_i) begin
            if (32'(div_q) >= DecFloor) div_d = div_q - Step;
            else                        div_d = MinDiv;
        end else if (speed_down_i && !speed_up_i) begin
            if (32'(div_q) + DIV_STEP <= DIV_MAX) div_d = div_q + Step;
            else                                  div_d = MaxDiv;
        end
    end

    // Tick counter: pulse on terminal count; silent reload if the divisor shrank under the count
    always_comb begin
        tick_d = 1'b0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q >= div_q) begin
            cnt_d = '0;
        end else if (cnt_q == div_q - 1'b1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Divisor, counter and tick registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= DefDiv;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign clk_div_o   = div_q;
    assign audio_clk_o = tick_q;

endmodule

// File: rtl/playback_controller.sv
// Playback controller: key-command decode, word-issue FSM and sample-tick generation.
module playback_controller
    import playback_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV_DEFAULT = DIV_DEFAULT,
    parameter int unsigned DIV_STEP        = DIV_STEP_DEFAULT,
    parameter int unsigned DIV_MIN         = DIV_MIN_DEFAULT,
    parameter int unsigned DIV_MAX         = DIV_MAX_DEFAULT
) (
    input  logic             inclk,
    input  logic             reset_n,
    input  logic             key_valid,
    input  logic [7:0]       key_code,
    input  logic             speed_up,
    input  logic             speed_down,
    input  logic             speed_reset,
    input  logic             gen_finish,
    output logic             start_read,
    output logic             direction,
    output logic             restart,
    output logic             audio_clk,
    output logic             playing,
    output logic [DIV_W-1:0] clk_div
);

    state_e state_q;
    logic   start_read_q;
    logic   direction_q;
    logic   play_q;
    logic   pend_dir_q;
    logic   restart_q;

    logic   key_play, key_pause, key_fwd, key_back, key_restart;

    // Command decode; unknown codes fall through as no-ops
    always_comb begin
        key_play    = key_valid && (key_code == KEY_PLAY);
        key_pause   = key_valid && (key_code == KEY_PAUSE);
        key_fwd     = key_valid && (key_code == KEY_FORWARD);
        key_back    = key_valid && (key_code == KEY_BACK);
        key_restart = key_valid && (key_code == KEY_RESTART);
    end

    // Word-issue FSM; direction only changes on entry to ISSUE so a word never flips mid-flight
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StPaused;
            start_read_q <= 1'b0;
            direction_q  <= 1'b0;
        end else begin
            start_read_q <= 1'b0;
            case (state_q)
                StPaused: begin
                    if (play_q) begin
                        state_q      <= StIssue;
                        start_read_q <= 1'b1;
                        direction_q  <= pend_dir_q;
                    end
                end
                StIssue: begin
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (gen_finish) begin
                        if (play_q) begin
                            state_q      <= StIssue;
                            start_read_q <= 1'b1;
                            direction_q  <= pend_dir_q;
                        end else begin
                            state_q <= StPaused;
                        end
                    end
                end
                default: begin
                    state_q <= StPaused;
                end
            endcase
        end
    end

    // Play flag and pending direction, updated by key commands in any state
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            play_q     <= 1'b0;
            pend_dir_q <= 1'b0;
        end else begin
            if (key_play)       play_q <= 1'b1;
            else if (key_pause) play_q <= 1'b0;
            if (key_fwd)        pend_dir_q <= 1'b0;
            else if (key_back)  pend_dir_q <= 1'b1;
        end
    end

    // Restart level: a new 'R' beats a coinciding gen_finish
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            restart_q <= 1'b0;
        end else if (key_restart) begin
            restart_q <= 1'b1;
        end else if (gen_finish) begin
            restart_q <= 1'b0;
        end
    end

    sample_tick_gen #(
        .CLK_DIV_DEFAULT (CLK_DIV_DEFAULT),
        .DIV_STEP        (DIV_STEP),
        .DIV_MIN         (DIV_MIN),
        .DIV_MAX         (DIV_MAX)
    ) u_sample_tick_gen (
        .clk_i         (inclk),
        .rst_ni        (reset_n),
        .speed_up_i    (speed_up),
        .speed_down_i  (speed_down),
        .speed_reset_i (speed_reset),
        .clk_div_o     (clk_div),
        .audio_clk_o   (audio_clk)
    );

    assign start_read = start_read_q;
    assign direction  = direction_q;
    assign restart    = restart_q;
    assign playing    = play_q;

endmodule

// File: tb/tb_playback_controller.sv
// Bench for playback_controller: behavioural reference model, per-cycle compare, directed and random stimulus.
module tb_playback_controller;

    logic        inclk = 1'b0;
    logic        reset_n;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        speed_up, speed_down, speed_reset, gen_finish;
    logic        start_read, direction, restart, audio_clk, playing;
    logic [15:0] clk_div;

    int vectors    = 0;
    int miscompares = 0;

    playback_controller dut (
        .inclk       (inclk),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .speed_up    (speed_up),
        .speed_down  (speed_down),
        .speed_reset (speed_reset),
        .gen_finish  (gen_finish),
        .start_read  (start_read),
        .direction   (direction),
        .restart     (restart),
        .audio_clk   (audio_clk),
        .playing     (playing),
        .clk_div     (clk_div)
    );

    always #5 inclk = ~inclk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_busy: a word has been requested and its gen_finish has not yet been accepted.
    bit m_busy, m_start, m_play, m_dir, m_pend, m_restart, m_tick;
    int m_div, m_cnt;
    bit m_issue;

    function automatic int next_div(input int d, input bit up, input bit dn, input bit rs);
        if (rs) return 2272;
        if (up && !dn) return (d - 16 < 256) ? 256 : d - 16;
        if (dn && !up) return (d + 16 > 8192) ? 8192 : d + 16;
        return d;
    endfunction

    // A new word is requested when idle and playing, or when the current word finishes while playing.
    // The cycle right after a request is never a request (the fetch strobe lasts one cycle).
    assign m_issue = !m_start && (m_busy ? (gen_finish && m_play) : m_play);

    always @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_start <= 0; m_play <= 0; m_dir <= 0; m_pend <= 0;
            m_restart <= 0; m_tick <= 0; m_div <= 2272; m_cnt <= 0;
        end else begin
            m_start <= m_issue;
            if (m_issue) begin
                m_busy <= 1;
                m_dir  <= m_pend;
            end else if (m_busy && !m_start && gen_finish) begin
                m_busy <= 0;
            end
            if (key_valid && key_code == 8'h45) m_play <= 1;
            if (key_valid && key_code == 8'h44) m_play <= 0;
            if (key_valid && key_code == 8'h46) m_pend <= 0;
            if (key_valid && key_code == 8'h42) m_pend <= 1;
            if (key_valid && key_code == 8'h52) m_restart <= 1;
            else if (gen_finish)                m_restart <= 0;
            m_div  <= next_div(m_div, speed_up, speed_down, speed_reset);
            m_cnt  <= (m_cnt >= m_div - 1) ? 0 : m_cnt + 1;
            m_tick <= (m_cnt == m_div - 1);
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge inclk) begin
        chk("start_read", int'(start_read), int'(m_start));
        chk("direction",  int'(direction),  int'(m_dir));
        chk("restart",    int'(restart),    int'(m_restart));
        chk("audio_clk",  int'(audio_clk),  int'(m_tick));
        chk("playing",    int'(playing),    int'(m_play));
        chk("clk_div",    int'(clk_div),    m_div);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge inclk);
        #1;
        key_valid = 0; key_code = 8'h00;
        speed_up = 0; speed_down = 0; speed_reset = 0; gen_finish = 0;
    endtask

    task automatic key(input logic [7:0] c);
        key_valid = 1; key_code = c;
        tick();
    endtask

    initial begin
        int n, hi;
        bit found;
        logic [7:0] codes [6];
        codes[0] = 8'h45; codes[1] = 8'h44; codes[2] = 8'h46;
        codes[3] = 8'h42; codes[4] = 8'h52; codes[5] = 8'h00;

        key_valid = 0; key_code = 0; speed_up = 0; speed_down = 0;
        speed_reset = 0; gen_finish = 0;
        reset_n = 1;
        #1 reset_n = 0;
        repeat (3) @(posedge inclk);
        #1;
        chk("rst_clk_div", int'(clk_div), 2272);
        chk("rst_start_read", int'(start_read), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_audio_clk", int'(audio_clk), 0);
        reset_n = 1;
        tick(); tick();

        // Play: strobe two cycles after 'E', next word one cycle after finish
        key(8'h45);
        chk("e_latch_no_read", int'(start_read), 0);
        chk("e_playing", int'(playing), 1);
        tick();
        chk("e_first_read", int'(start_read), 1);
        tick();
        chk("read_one_cycle", int'(start_read), 0);
        repeat (8) tick();
        gen_finish = 1; tick();
        chk("next_read_after_finish", int'(start_read), 1);

        // Pause mid-word: word completes, no further read
        tick();
        key(8'h44);
        chk("pause_playing", int'(playing), 0);
        tick();
        gen_finish = 1; tick();
        chk("pause_no_read", int'(start_read), 0);
        repeat (5) tick();
        chk("paused_still_no_read", int'(start_read), 0);

        // Backward mid-word: direction changes only at the next issue
        key(8'h45);
        chk("dir_first_word", int'(direction), 0);
        tick();
        chk("replay_read", int'(start_read), 1);
        tick();
        key(8'h42);
        chk("dir_held_midword", int'(direction), 0);
        tick();
        gen_finish = 1; tick();
        chk("dir_at_issue", int'(direction), 1);
        chk("read_at_dir_issue", int'(start_read), 1);
        tick();

        // Restart level until finish; R with finish keeps it set
        key(8'h52);
        hi = int'(restart);
        repeat (4) begin
            tick();
            hi += int'(restart);
        end
        gen_finish = 1; tick();
        chk("restart_hi_cycles", hi, 5);
        chk("restart_cleared", int'(restart), 0);
        tick();
        key_valid = 1; key_code = 8'h52; gen_finish = 1; tick();
        chk("restart_r_wins", int'(restart), 1);
        gen_finish = 1; tick();
        chk("restart_clear_outside_wait", int'(restart), 0);
        key(8'h44);
        repeat (3) tick();
        gen_finish = 1; tick();
        tick();

        // Speed saturation and audio tick period
        repeat (200) begin speed_up = 1; tick(); end
        chk("div_min_sat", int'(clk_div), 256);
        speed_up = 1; speed_down = 1; tick();
        chk("div_up_down_cancel", int'(clk_div), 256);
        speed_down = 1; tick();
        chk("div_step_down", int'(clk_div), 272);
        speed_reset = 1; speed_up = 1; tick();
        chk("div_reset_wins", int'(clk_div), 2272);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (audio_clk) found = 1;
        end
        chk("audio_tick_seen", int'(found), 1);
        n = 0;
        found = 0;
        while (!found && n < 3000) begin
            tick();
            n++;
            if (audio_clk) found = 1;
        end
        chk("audio_period", n, 2272);
        repeat (400) begin speed_down = 1; tick(); end
        chk("div_max_sat", int'(clk_div), 8192);
        speed_reset = 1; tick();

        // Async reset mid-word with a non-default divisor
        repeat (110) begin speed_up = 1; tick(); end
        chk("div_512", int'(clk_div), 512);
        key(8'h45);
        key(8'h46);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (start_read) found = 1;
            else tick();
        end
        chk("issue_before_reset", int'(found), 1);
        tick();
        reset_n = 0;
        #2;
        chk("arst_start_read", int'(start_read), 0);
        chk("arst_playing", int'(playing), 0);
        chk("arst_restart", int'(restart), 0);
        chk("arst_direction", int'(direction), 0);
        chk("arst_audio_clk", int'(audio_clk), 0);
        chk("arst_clk_div", int'(clk_div), 2272);
        @(posedge inclk); #1;
        reset_n = 1;
        repeat (5) tick();
        chk("no_issue_after_reset", int'(start_read), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            key_valid = ($urandom_range(0, 7) == 0);
            key_code  = codes[$urandom_range(0, 5)];
            if (key_code == 8'h00) key_code = 8'($urandom);
            r = $urandom_range(0, 99);
            speed_up    = (r < 8) || (r == 20);
            speed_down  = (r >= 8 && r < 14) || (r == 20);
            speed_reset = (r == 21);
            gen_finish  = ($urandom_range(0, 5) == 0);
            if (i == 2000) begin
                reset_n = 0;
                #1 reset_n = 1;
            end
            @(posedge inclk); #1;
            key_valid = 0; speed_up = 0; speed_down = 0; speed_reset = 0; gen_finish = 0;
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
